pipeline_carry_skip_adder_param: RTL and testbench

//  Parametrised, valid/ready pipelined carry-skip adder: sum = a + b + cin at configurable WIDTH, block size and depth.

---
 rtl/adder_pkg.sv | 27 ++
 rtl/csa_block.sv | 24 ++
 rtl/pipeline_carry_skip_adder_param.sv | 149 ++++++++++++++
 tb/tb_pipeline_carry_skip_adder_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry-skip adder: block/stage slicing and a
// legality check for the WIDTH/BLOCK/STAGES combination.
package adder_pkg;

  // Number of BLOCK-bit carry-skip blocks across the operand width.
  function automatic int unsigned calc_nblk(input int unsigned width, input int unsigned block);
    return (block == 0) ? 1 : width / block;
  endfunction

  // Blocks handled per pipeline stage; clamped to 1 so an illegal setup still elaborates far
  // enough to hit the $error instead of dividing by zero.
  function automatic int unsigned calc_bps(input int unsigned width, input int unsigned block,
                                           input int unsigned stages);
    int unsigned nblk;
    nblk = calc_nblk(width, block);
    return (stages == 0 || nblk < stages) ? 1 : nblk / stages;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned block,
                                   input int unsigned stages);
    if (width == 0 || block == 0 || stages == 0) return 1'b0;
    if (width % block != 0) return 1'b0;
    if ((width / block) % stages != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One combinational BLOCK-bit carry-skip block: ripple sum plus a skip path that forwards
// the carry-in straight to the carry-out when every bit propagates.
module csa_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic             p;
  logic [BLOCK:0]   rsum;

  // Ripple add for the sum bits; skip mux selects the carry-out.
  always_comb begin
    p    = &(a ^ b);
    rsum = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, ci};
    s    = rsum[BLOCK-1:0];
    co   = p ? ci : rsum[BLOCK];
  end

endmodule

// File: rtl/pipeline_carry_skip_adder_param.sv
// Valid/ready pipelined carry-skip adder: {cout, sum} = a + b + cin.
// Registered input, STAGES carry stages, registered output; latency STAGES+2.
// Operand slices not yet consumed travel down skew registers; finished sum slices
// travel down deskew registers so the whole word leaves aligned.
// Optional feature: define ADDER_OVF_EN to add the signed-overflow output ovf.
module pipeline_carry_skip_adder_param
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK = calc_nblk(WIDTH, BLOCK);
  localparam int unsigned BPS  = calc_bps(WIDTH, BLOCK, STAGES);
  localparam int unsigned SW   = BPS * BLOCK;

  if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $error("pipeline_carry_skip_adder_param: illegal WIDTH/BLOCK/STAGES combination");
  end

  // Index 0 is the input register; index s+1 is the output of carry stage s.
  logic             v_q   [STAGES+1];
  logic             c_q   [STAGES+1];
  // Index 0 is the input register; index s is the skew copy feeding stage s.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  // sum_q[s] holds every slice finished up to and including stage s.
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_d   [STAGES];

  logic [WIDTH-1:0] blk_sum;
  logic [NBLK-1:0]  blk_co;
  logic             en;

  // Global stall: everything advances together or holds together.
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    localparam int unsigned Stg = gi / BPS;
    logic ci;
    if (gi % BPS == 0) begin : g_first
      assign ci = c_q[Stg];
    end else begin : g_chain
      assign ci = blk_co[gi-1];
    end
    csa_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a (a_q[Stg][gi*BLOCK +: BLOCK]),
      .b (b_q[Stg][gi*BLOCK +: BLOCK]),
      .ci(ci),
      .s (blk_sum[gi*BLOCK +: BLOCK]),
      .co(blk_co[gi])
    );
  end

  // The last skew copy only has its top slice consumed.
  logic unused_skew;
  assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

  // Merge each stage's new slice into the deskewed partial sum and pick its carry-out.
  always_comb begin
    sum_d[0]            = '0;
    sum_d[0][SW-1:0]    = blk_sum[SW-1:0];
    c_d[0]              = blk_co[BPS-1];
    for (int unsigned s = 1; s < STAGES; s++) begin
      sum_d[s]              = sum_q[s-1];
      sum_d[s][s*SW +: SW]  = blk_sum[s*SW +: SW];
      c_d[s]                = blk_co[(s+1)*BPS-1];
    end
  end

`ifdef ADDER_OVF_EN
  logic ovf_st_q;
  logic ovf_st_d;

  // Sign overflow from the operand MSBs still in the last skew copy and the finished MSB.
  always_comb begin
    ovf_st_d = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
               (sum_d[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  end

  // ovf shadows the last stage and output register so it stays aligned with sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_st_q <= 1'b0;
      ovf      <= 1'b0;
    end else if (en) begin
      ovf_st_q <= ovf_st_d;
      ovf      <= ovf_st_q;
    end
  end
`endif

  // Pipeline registers: input, carry stages with skew/deskew, and output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s <= STAGES; s++) begin
        v_q[s] <= 1'b0;
        c_q[s] <= 1'b0;
      end
      for (int unsigned s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (en) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= b;
      c_q[0] <= cin;
      for (int unsigned s = 0; s < STAGES; s++) begin
        v_q[s+1] <= v_q[s];
        c_q[s+1] <= c_d[s];
        sum_q[s] <= sum_d[s];
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
        a_q[s] <= a_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      out_valid <= v_q[STAGES];
      sum       <= sum_q[STAGES-1];
      cout      <= c_q[STAGES];
    end
  end

endmodule

// File: tb/tb_pipeline_carry_skip_adder_param.sv
// Bench for the pipelined carry-skip adder: a 64/4/4 instance and a 16/4/1 instance share
// stimulus; a queue scoreboard predicts {ovf, cout, sum} from plain integer addition.
module tb_pipeline_carry_skip_adder_param;

  typedef struct {
    logic [64:0] res;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin, out_ready;
  logic [63:0] a, b;
  logic        in_ready, out_valid, cout;
  logic [63:0] sum;
  logic        in_ready16, out_valid16, cout16;
  logic [15:0] sum16;
  logic        o64, o16;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   chk_lat  = 1'b0;
  exp_t q64[$];
  exp_t q16[$];

`ifdef ADDER_OVF_EN
  logic ovf, ovf16;
  assign o64 = ovf;
  assign o16 = ovf16;
`else
  assign o64 = 1'b0;
  assign o16 = 1'b0;
`endif

  pipeline_carry_skip_adder_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipeline_carry_skip_adder_param #(
    .WIDTH(16), .BLOCK(4), .STAGES(1)
  ) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .a(a[15:0]),
    .b(b[15:0]), .cin(cin), .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
    .cout(cout16)
`ifdef ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: w-bit a+b+cin by integer addition; signed overflow from operand/result signs.
  function automatic exp_t model(input int unsigned w, input logic [63:0] x, input logic [63:0] y,
                                 input logic c);
    exp_t        e;
    logic [63:0] m, xm, ym;
    logic [64:0] full;
    m    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & m;
    ym   = y & m;
    full = {1'b0, xm} + {1'b0, ym} + 65'(c);
    e.res = full;
    e.ovf = 1'b0;
`ifdef ADDER_OVF_EN
    e.ovf = (xm[w-1] == ym[w-1]) && (full[w-1] != xm[w-1]);
`endif
    e.acc = cyc;
    return e;
  endfunction

  // One clock: drive at the falling edge, score the handshakes the next rising edge will take.
  task automatic cycle(input logic r, input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                       input logic ic, input logic ordy);
    exp_t e;
    rst = r; in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    if (r) begin
      q64.delete();
      q16.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q64.size() == 0) check_eq("out64_unexpected", 128'(out_valid), 128'(0));
        else begin
          e = q64.pop_front();
          check_eq("res64", 128'({o64, cout, sum}), 128'({e.ovf, e.res}));
          if (chk_lat) check_eq("lat64", 128'(cyc - e.acc), 128'(6));
        end
      end
      if (out_valid16 && out_ready) begin
        if (q16.size() == 0) check_eq("out16_unexpected", 128'(out_valid16), 128'(0));
        else begin
          e = q16.pop_front();
          check_eq("res16", 128'({o16, cout16, sum16}), 128'({e.ovf, e.res[16:0]}));
          if (chk_lat) check_eq("lat16", 128'(cyc - e.acc), 128'(3));
        end
      end
      if (in_valid && in_ready) q64.push_back(model(64, a, b, cin));
      if (in_valid && in_ready16) q16.push_back(model(16, a, b, cin));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic rnd_ops(output logic [63:0] x, output logic [63:0] y);
    int unsigned mode;
    mode = $urandom_range(0, 7);
    x = {$urandom(), $urandom()};
    y = {$urandom(), $urandom()};
    if (mode == 0) y = ~x;                 // every block propagates
    else if (mode == 1) x = '1;
    else if (mode == 2) y = 64'd1;
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy);
    logic [63:0] x, y;
    rnd_ops(x, y);
    cycle(1'b0, iv, x, y, 1'($urandom_range(0, 1)), ordy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  logic [63:0] snap_sum;
  logic        snap_c;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_sum", 128'(sum), 128'(0));
    check_eq("rst_cout", 128'(cout), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_out_valid16", 128'(out_valid16), 128'(0));

    // Directed corner vectors, latency checked on each.
    chk_lat = 1'b1;
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
    idle(8);
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
    idle(8);

    // Back-to-back random stream with no backpressure.
    for (int i = 0; i < 1000; i++) rnd_cycle(1'b1, 1'b1);
    idle(8);
    check_eq("b2b_drain64", 128'(q64.size()), 128'(0));

    // Fill under backpressure, then hold for 5 cycles.
    chk_lat = 1'b0;
    for (int i = 0; i < 12; i++) rnd_cycle(1'b1, 1'b0);
    snap_sum = sum;
    snap_c   = cout;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_in_ready", 128'(in_ready), 128'(0));
      check_eq("stall_in_ready16", 128'(in_ready16), 128'(0));
      check_eq("stall_hold", 128'({snap_c, snap_sum}), 128'({cout, sum}));
      rnd_cycle(1'b1, 1'b0);
    end
    for (int i = 0; i < 20; i++) rnd_cycle(1'b1, 1'b1);
    idle(12);
    check_eq("stall_drain64", 128'(q64.size()), 128'(0));
    check_eq("stall_drain16", 128'(q16.size()), 128'(0));

    // Reset mid-stream flushes everything in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) rnd_cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
    check_eq("midrst_sum", 128'(sum), 128'(0));
    check_eq("midrst_out_valid16", 128'(out_valid16), 128'(0));
    for (int i = 0; i < 30; i++) rnd_cycle(1'b1, 1'b1);
    idle(10);
    check_eq("midrst_drain64", 128'(q64.size()), 128'(0));

    // Random input gaps and random backpressure.
    chk_lat = 1'b0;
    for (int i = 0; i < 400; i++)
      rnd_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    idle(12);
    check_eq("gap_drain64", 128'(q64.size()), 128'(0));
    check_eq("gap_drain16", 128'(q16.size()), 128'(0));
    check_eq("gap_idle_out_valid", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
